// File: rtl/mcm_pkg.sv
// Shared definitions for the constant-multiplier block family and its divider.
// Holds the divider FSM states, the default constant pair and quotient-range helpers.
package mcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default constant, also used by the multiplier block generator.
    localparam longint CONST_DEFAULT   = 64'd86746874;
    localparam int     CONST_W_DEFAULT = 27;

    // Largest positive quotient and largest negative quotient magnitude for a qw-bit signed result.
    function automatic longint q_max_pos(input int qw);
        return (longint'(1) << (qw - 1)) - 1;
    endfunction

    function automatic longint q_max_neg_mag(input int qw);
        return longint'(1) << (qw - 1);
    endfunction

endpackage

// File: rtl/mcm_const_div_step.sv
// One restoring-division step: shifts a bit into the partial remainder and
// subtracts the divisor when it fits.
module mcm_div_step #(
    parameter int CONST_W = 27
) (
    input  logic [CONST_W-1:0] r,
    input  logic               bit_in,
    input  logic [CONST_W-1:0] divisor,
    output logic [CONST_W-1:0] r_next,
    output logic               qbit
);

    logic [CONST_W:0] t;
    logic [CONST_W:0] diff;

    assign t      = {r, bit_in};
    assign diff   = t - {1'b0, divisor};
    assign qbit   = (t >= {1'b0, divisor});
    // The difference is below the divisor whenever the remainder was valid, so CONST_W bits suffice.
    assign r_next = qbit ? CONST_W'(diff) : CONST_W'(t);

endmodule

// File: rtl/mcm_const_div.sv
// Recovers a signed multiplicand X from P = X*CONST by sequential restoring
// division, one quotient bit per cycle, with valid/ready handshakes on both sides.
module mcm_const_div
    import mcm_pkg::*;
#(
    parameter int     P_W     = 35,
    parameter int     Q_W     = 8,
    parameter int     CONST_W = CONST_W_DEFAULT,
    parameter longint CONST   = CONST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [P_W-1:0] P_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [Q_W-1:0] Q_out,
    output logic signed [CONST_W:0] R_out,
    output logic                  exact,
    output logic                  ovf
);

    localparam int CNT_W = (Q_W > 2) ? $clog2(Q_W) : 1;
    localparam int CMP_W = (P_W > CONST_W + 1) ? P_W : CONST_W + 1;
    localparam logic [CONST_W-1:0] DIVISOR       = CONST_W'(CONST);
    localparam logic [Q_W-1:0]     Q_MAX_POS     = Q_W'(q_max_pos(Q_W));
    localparam logic [Q_W-1:0]     Q_MAX_NEG_MAG = Q_W'(q_max_neg_mag(Q_W));
    localparam logic [CNT_W-1:0]   CNT_START     = CNT_W'(Q_W - 1);

    state_t             state_reg, state_next;
    logic               sgn_reg;
    logic               pre_ovf_reg;
    logic [CONST_W-1:0] r_reg;
    logic [Q_W-1:0]     s_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [P_W-1:0]     p_raw;
    logic [P_W-1:0]     mag;
    logic [P_W-1:0]     hi;
    logic               pre_ovf_in;
    logic [CONST_W-1:0] step_r;
    logic               step_q;
    logic               ovf_fix;
    logic [CONST_W:0]   r_ext;

    // Magnitude is taken as unsigned so the most-negative product needs no extra bit.
    assign p_raw      = P_in;
    assign mag        = p_raw[P_W-1] ? ((~p_raw) + {{(P_W-1){1'b0}}, 1'b1}) : p_raw;
    assign hi         = mag >> Q_W;
    assign pre_ovf_in = (CMP_W'(hi) >= CMP_W'(DIVISOR));

    assign in_ready = (state_reg == IDLE);

    mcm_div_step #(
        .CONST_W (CONST_W)
    ) u_step (
        .r       (r_reg),
        .bit_in  (s_reg[Q_W-1]),
        .divisor (DIVISOR),
        .r_next  (step_r),
        .qbit    (step_q)
    );

    assign ovf_fix = pre_ovf_reg
                   | (!sgn_reg && (s_reg > Q_MAX_POS))
                   | ( sgn_reg && (s_reg > Q_MAX_NEG_MAG));
    assign r_ext   = {1'b0, r_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)           state_next = DIV;
            DIV:     if (cnt_reg == '0)      state_next = FIX;
            FIX:                             state_next = DONE;
            DONE:    if (out_ready)          state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_reg     <= 1'b0;
            pre_ovf_reg <= 1'b0;
            r_reg       <= '0;
            s_reg       <= '0;
            cnt_reg     <= '0;
            out_valid   <= 1'b0;
            Q_out       <= '0;
            R_out       <= '0;
            exact       <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sgn_reg     <= p_raw[P_W-1];
                        pre_ovf_reg <= pre_ovf_in;
                        r_reg       <= CONST_W'(hi);
                        s_reg       <= mag[Q_W-1:0];
                        cnt_reg     <= CNT_START;
                    end
                end
                DIV: begin
                    // Quotient bits replace dividend bits in the shift register as they are consumed.
                    r_reg   <= step_r;
                    s_reg   <= {s_reg[Q_W-2:0], step_q};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    out_valid <= 1'b1;
                    ovf       <= ovf_fix;
                    if (ovf_fix) begin
                        Q_out <= '0;
                        R_out <= '0;
                        exact <= 1'b0;
                    end else begin
                        Q_out <= sgn_reg ? ((~s_reg) + {{(Q_W-1){1'b0}}, 1'b1}) : s_reg;
                        R_out <= sgn_reg ? ((~r_ext) + {{CONST_W{1'b0}}, 1'b1}) : r_ext;
                        exact <= (r_reg == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
